hdmi_src_sched: RTL and testbench
=================================

Name: hdmi_src_sched

Overview:
Pixel-source scheduler between the frame-level pixel producers and the VGA timing generator that feeds the HDMI transmitter. It answers each vga_data_request with one 24-bit RGB pixel from one of three sources: source 0 (camera line FIFO), source 1 (image/overlay FIFO), or an internal colour-bar generator. Source selection changes only at frame boundaries. Source underflow is substituted with a fallback colour and counted.

Parameters:
H_ACTIVE, 1280, active pixels per line; sets colour-bar width BAR_W = H_ACTIVE/8.
VSYNC_POL, 1, level of i_vga_vsync during the sync pulse.
FALLBACK_RGB, 24'h000000, pixel driven on underflow or before the first frame start.

Ports:
i_clk_1x  in  1  pixel clock (1x); only clock.
i_rst  in  1  synchronous reset, active-high.
i_vga_vsync  in  1  vertical sync from the VGA timing generator.
vga_data_request  in  1  pixel request from the VGA timing generator.
vga_data  out  24  pixel answer, RGB888, registered.
i_sel  in  2  requested source: 0 = src0, 1 = src1, 2 or 3 = colour bars.
i_src0_data  in  24  src0 first-word-fall-through FIFO data.
i_src0_empty  in  1  src0 FIFO empty.
o_src0_rd  out  1  src0 read strobe.
i_src1_data  in  24  src1 FWFT FIFO data.
i_src1_empty  in  1  src1 FIFO empty.
o_src1_rd  out  1  src1 read strobe.
i_clr  in  1  clears o_underflow.
o_active_sel  out  2  source in effect for the current frame.
o_frame_start  out  1  one-cycle pulse when a new frame's selection is applied.
o_underflow  out  1  sticky underflow flag.
o_underflow_cnt  out  16  underflow count of the previous frame, saturating.

Behaviour:
- One clock domain, i_clk_1x. Reset is synchronous and active-high; all state is updated on the rising edge.
- Reset values:
  - vga_data = 0, o_src0_rd = 0, o_src1_rd = 0, o_frame_start = 0.
  - o_active_sel = 2, o_underflow = 0, o_underflow_cnt = 0.
  - Internal: live counter = 0, x counter = 0, vs_d = 0, FSM = WAIT_FRAME.
- Sync detect: vs_act = (i_vga_vsync == VSYNC_POL). vs_d is the registered copy of vs_act. Frame start (FS) is vs_act & ~vs_d.
- FSM states:
  - WAIT_FRAME: every request is answered with FALLBACK_RGB; no source reads.
  - RUN: normal service.
  - Transitions: FS moves WAIT_FRAME -> RUN. FS in RUN stays in RUN. Reset returns to WAIT_FRAME.
- On the edge after an FS cycle:
  - o_active_sel <= (i_sel == 3 ? 2 : i_sel).
  - o_frame_start pulses 1 for exactly one cycle.
  - o_underflow_cnt <= live counter; live counter <= 0.
- Changes on i_sel between frame starts have no effect.
- Latency: request sampled high in cycle t gives the answer on vga_data in cycle t+1. On cycles where the request is low, vga_data <= 0.
- Read strobe timing: o_srcN_rd is combinational in cycle t. It is gated by RUN, ~i_rst, the request, o_active_sel == N, and ~i_srcN_empty.
- Serving src N in RUN:
  - If not empty: o_srcN_rd = 1 and vga_data <= i_srcN_data.
  - If empty: no read, vga_data <= FALLBACK_RGB, live counter += 1 (saturating at 16'hFFFF), o_underflow <= 1.
- Never more than one read strobe is high in a cycle. The unselected FIFO is never read.
- Colour bars (o_active_sel == 2):
  - x counter increments on every request cycle and returns to 0 on every non-request cycle, i.e. at each line end.
  - bar = x / BAR_W, clamped to 7.
  - Bar colours in order: FFFFFF, FFFF00, 00FFFF, 00FF00, FF00FF, FF0000, 0000FF, 000000.
  - The x counter runs in every state but is used only for the bars.
- Simultaneous events:
  - Underflow and i_clr in the same cycle: o_underflow = 1 (set wins).
  - FS together with a request: the request is served under the old o_active_sel.
  - FS together with an underflow: that underflow goes into the live counter after the reset to 0, i.e. live = 1.
- Reset mid-line: the strobe drops in the same cycle i_rst is high. Nothing is partially consumed, and the first frame after reset again waits for FS.

Test Plan:
1. Reset, then requests without vsync -> vga_data = FALLBACK_RGB one cycle after each request; o_src0_rd and o_src1_rd stay 0; o_active_sel = 2.
2. i_sel = 2, vsync pulse, then a 1280-cycle request burst -> o_frame_start pulses once. Pixels 0..159 = FFFFFF, 160..319 = FFFF00, ..., 1120..1279 = 000000, each appearing at t+1.
3. i_sel = 0, frame start, src0 holds 4 words A1..A4, 6 requests -> o_src0_rd high on 4 cycles; output A1..A4, then 000000 twice. o_underflow = 1; at the next frame start o_underflow_cnt = 2.
4. i_sel switched 0 -> 1 mid-frame -> o_active_sel stays 0 and src1 is never read until the next vsync edge; then o_active_sel = 1.
5. i_clr and an underflow in the same cycle -> o_underflow remains 1. i_clr alone -> 0 the next cycle.
6. i_rst asserted mid-burst in RUN with src0 non-empty -> o_src0_rd = 0 in that cycle; the next cycle shows all reset values; requests give FALLBACK_RGB until vsync.

Source files
------------

// File: rtl/hdmi_src_sched.sv
// Pixel-source scheduler: answers each VGA pixel request with one RGB888 word
// taken from src0, from src1 or from an internal colour-bar generator. The source
// is latched at each frame start. An empty FIFO is replaced by a fallback colour,
// and each such underflow is counted per frame.
module hdmi_src_sched #(
  parameter int          H_ACTIVE     = 1280,
  parameter logic        VSYNC_POL    = 1'b1,
  parameter logic [23:0] FALLBACK_RGB = 24'h000000
) (
  input  logic        i_clk_1x,
  input  logic        i_rst,
  input  logic        i_vga_vsync,
  input  logic        vga_data_request,
  output logic [23:0] vga_data,
  input  logic [1:0]  i_sel,
  input  logic [23:0] i_src0_data,
  input  logic        i_src0_empty,
  output logic        o_src0_rd,
  input  logic [23:0] i_src1_data,
  input  logic        i_src1_empty,
  output logic        o_src1_rd,
  input  logic        i_clr,
  output logic [1:0]  o_active_sel,
  output logic        o_frame_start,
  output logic        o_underflow,
  output logic [15:0] o_underflow_cnt
);

  localparam int XW = 16;
  localparam logic [XW-1:0] BAR_W = XW'(H_ACTIVE / 8);
  localparam logic [XW-1:0] X_MAX = '1;

  typedef enum logic {WAIT_FRAME, RUN} state_t;

  state_t        state_q, state_d;
  logic          vs_d_q, vs_d_d;
  logic [XW-1:0] x_q, x_d;
  logic [15:0]   live_q, live_d;
  logic [15:0]   cnt_q, cnt_d;
  logic [1:0]    sel_q, sel_d;
  logic          frame_start_q, frame_start_d;
  logic          underflow_q, underflow_d;
  logic [23:0]   data_q, data_d;

  logic          vs_act, fs;
  logic          rd0, rd1, uf_now;
  logic [XW-1:0] bar_idx;
  logic [2:0]    bar;

  function automatic logic [23:0] bar_colour(input logic [2:0] b);
    case (b)
      3'd0:    bar_colour = 24'hFFFFFF;
      3'd1:    bar_colour = 24'hFFFF00;
      3'd2:    bar_colour = 24'h00FFFF;
      3'd3:    bar_colour = 24'h00FF00;
      3'd4:    bar_colour = 24'hFF00FF;
      3'd5:    bar_colour = 24'hFF0000;
      3'd6:    bar_colour = 24'h0000FF;
      default: bar_colour = 24'h000000;
    endcase
  endfunction

  assign vs_act  = (i_vga_vsync == VSYNC_POL);
  assign fs      = vs_act & ~vs_d_q;
  assign bar_idx = x_q / BAR_W;
  assign bar     = (bar_idx > XW'(7)) ? 3'd7 : bar_idx[2:0];

  // FSM next state, read strobes and the pixel answer for this request
  always_comb begin
    state_d = state_q;
    rd0     = 1'b0;
    rd1     = 1'b0;
    uf_now  = 1'b0;
    data_d  = '0;
    if (fs) state_d = RUN;
    if (vga_data_request) begin
      if (state_q == WAIT_FRAME) begin
        data_d = FALLBACK_RGB;
      end else begin
        case (sel_q)
          2'd0: begin
            if (i_src0_empty) begin
              data_d = FALLBACK_RGB;
              uf_now = 1'b1;
            end else begin
              rd0    = ~i_rst;
              data_d = i_src0_data;
            end
          end
          2'd1: begin
            if (i_src1_empty) begin
              data_d = FALLBACK_RGB;
              uf_now = 1'b1;
            end else begin
              rd1    = ~i_rst;
              data_d = i_src1_data;
            end
          end
          default: data_d = bar_colour(bar);
        endcase
      end
    end
  end

  // Frame-boundary bookkeeping: sync edge, source latch, x position, underflow counters
  always_comb begin
    vs_d_d        = vs_act;
    frame_start_d = fs;
    sel_d         = sel_q;
    cnt_d         = cnt_q;
    live_d        = live_q;
    underflow_d   = underflow_q;
    if (vga_data_request) x_d = (x_q == X_MAX) ? x_q : x_q + XW'(1);
    else                  x_d = '0;
    if (fs) begin
      // An underflow on the frame-start cycle belongs to the new frame
      sel_d  = (i_sel == 2'd3) ? 2'd2 : i_sel;
      cnt_d  = live_q;
      live_d = uf_now ? 16'd1 : 16'd0;
    end else if (uf_now && live_q != 16'hFFFF) begin
      live_d = live_q + 16'd1;
    end
    if (uf_now)     underflow_d = 1'b1;
    else if (i_clr) underflow_d = 1'b0;
  end

  // State register with synchronous reset
  always_ff @(posedge i_clk_1x) begin
    if (i_rst) begin
      state_q       <= WAIT_FRAME;
      vs_d_q        <= 1'b0;
      x_q           <= '0;
      live_q        <= '0;
      cnt_q         <= '0;
      sel_q         <= 2'd2;
      frame_start_q <= 1'b0;
      underflow_q   <= 1'b0;
      data_q        <= '0;
    end else begin
      state_q       <= state_d;
      vs_d_q        <= vs_d_d;
      x_q           <= x_d;
      live_q        <= live_d;
      cnt_q         <= cnt_d;
      sel_q         <= sel_d;
      frame_start_q <= frame_start_d;
      underflow_q   <= underflow_d;
      data_q        <= data_d;
    end
  end

  assign vga_data        = data_q;
  assign o_src0_rd       = rd0;
  assign o_src1_rd       = rd1;
  assign o_active_sel    = sel_q;
  assign o_frame_start   = frame_start_q;
  assign o_underflow     = underflow_q;
  assign o_underflow_cnt = cnt_q;

endmodule

// File: tb/tb_hdmi_src_sched.sv
// Directed bench for hdmi_src_sched with hand-computed expected pixels and flags.
module tb_hdmi_src_sched;

  localparam logic [23:0] FB = 24'h0F0F0F;

  logic        clk = 1'b0;
  logic        rst, vsync, req, clr;
  logic [1:0]  sel;
  logic [23:0] d0, d1;
  logic        e0, e1;
  logic [23:0] vga_data;
  logic        rd0, rd1, fstart, uflow;
  logic [1:0]  asel;
  logic [15:0] ucnt;

  int n_vec = 0;
  int n_err = 0;

  logic [23:0] bars [8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                            24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};
  logic [23:0] a_words [4] = '{24'hA10001, 24'hA20002, 24'hA30003, 24'hA40004};

  always #5 clk = ~clk;

  hdmi_src_sched #(
    .H_ACTIVE(1280), .VSYNC_POL(1'b1), .FALLBACK_RGB(FB)
  ) dut (
    .i_clk_1x(clk), .i_rst(rst), .i_vga_vsync(vsync), .vga_data_request(req),
    .vga_data(vga_data), .i_sel(sel),
    .i_src0_data(d0), .i_src0_empty(e0), .o_src0_rd(rd0),
    .i_src1_data(d1), .i_src1_empty(e1), .o_src1_rd(rd1),
    .i_clr(clr), .o_active_sel(asel), .o_frame_start(fstart),
    .o_underflow(uflow), .o_underflow_cnt(ucnt)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // One request cycle: drive, check strobes combinationally, then the answer at t+1
  task automatic px(input logic r, input logic [23:0] w0, input logic m0,
                    input logic [23:0] w1, input logic m1,
                    input logic x_rd0, input logic x_rd1,
                    input logic [23:0] x_px, input string tag);
    req = r; d0 = w0; e0 = m0; d1 = w1; e1 = m1;
    #1;
    chk({tag, "_rd0"}, 32'(rd0), 32'(x_rd0));
    chk({tag, "_rd1"}, 32'(rd1), 32'(x_rd1));
    cyc();
    chk({tag, "_px"}, 32'(vga_data), 32'(x_px));
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_px"},    32'(vga_data), 32'h0);
    chk({tag, "_fs"},    32'(fstart),   32'h0);
    chk({tag, "_asel"},  32'(asel),     32'h2);
    chk({tag, "_uf"},    32'(uflow),    32'h0);
    chk({tag, "_ucnt"},  32'(ucnt),     32'h0);
  endtask

  initial begin
    rst = 1'b1; vsync = 1'b0; req = 1'b0; clr = 1'b0; sel = 2'd2;
    d0 = '0; d1 = '0; e0 = 1'b1; e1 = 1'b1;
    cyc(); cyc();
    chk_reset("reset");
    chk("reset_rd0", 32'(rd0), 32'h0);
    chk("reset_rd1", 32'(rd1), 32'h0);
    rst = 1'b0;

    // Before any frame start: fallback only, no reads even with data available
    sel = 2'd0;
    for (int k = 0; k < 3; k++)
      px(1'b1, 24'hAAAAAA, 1'b0, 24'hBBBBBB, 1'b0, 1'b0, 1'b0, FB, "wait");
    px(1'b0, 24'hAAAAAA, 1'b0, 24'hBBBBBB, 1'b0, 1'b0, 1'b0, 24'h0, "idle");
    chk("wait_asel", 32'(asel), 32'h2);

    // Colour bars over one full line
    sel = 2'd2; vsync = 1'b1;
    cyc();
    chk("bars_fs_hi", 32'(fstart), 32'h1);
    chk("bars_asel", 32'(asel), 32'h2);
    vsync = 1'b0;
    cyc();
    chk("bars_fs_lo", 32'(fstart), 32'h0);
    req = 1'b1;
    for (int i = 0; i < 1280; i++) begin
      cyc();
      chk("bar_px", 32'(vga_data), 32'(bars[i / 160]));
    end
    req = 1'b0;
    cyc();
    chk("bars_end", 32'(vga_data), 32'h0);

    // src0 with four words then two underflows
    sel = 2'd0; vsync = 1'b1;
    cyc();
    chk("s0_asel", 32'(asel), 32'h0);
    chk("s0_ucnt", 32'(ucnt), 32'h0);
    vsync = 1'b0;
    for (int k = 0; k < 6; k++)
      px(1'b1, (k < 4) ? a_words[k] : 24'h0, (k >= 4), 24'hBBBBBB, 1'b0,
         (k < 4), 1'b0, (k < 4) ? a_words[k] : FB, "src0");
    chk("s0_uf", 32'(uflow), 32'h1);

    // Selection change mid-frame has no effect until the next frame start
    sel = 2'd1;
    px(1'b1, 24'hB10001, 1'b0, 24'hD00000, 1'b0, 1'b1, 1'b0, 24'hB10001, "midsel");
    chk("midsel_asel", 32'(asel), 32'h0);
    vsync = 1'b1;
    px(1'b1, 24'hC10001, 1'b0, 24'hD00000, 1'b0, 1'b1, 1'b0, 24'hC10001, "fsreq");
    chk("fsreq_asel", 32'(asel), 32'h1);
    chk("fsreq_fs", 32'(fstart), 32'h1);
    chk("fsreq_ucnt", 32'(ucnt), 32'h2);
    vsync = 1'b0;
    px(1'b1, 24'hA10001, 1'b0, 24'hD10001, 1'b0, 1'b0, 1'b1, 24'hD10001, "src1");

    // Sticky flag: clear alone, set beats clear
    clr = 1'b1; req = 1'b0;
    cyc();
    chk("clr_alone", 32'(uflow), 32'h0);
    px(1'b1, 24'h0, 1'b0, 24'h0, 1'b1, 1'b0, 1'b0, FB, "ufclr");
    chk("ufclr_uf", 32'(uflow), 32'h1);
    px(1'b0, 24'h0, 1'b0, 24'h0, 1'b1, 1'b0, 1'b0, 24'h0, "clr2");
    chk("clr2_uf", 32'(uflow), 32'h0);
    clr = 1'b0;
    px(1'b1, 24'h0, 1'b0, 24'h0, 1'b1, 1'b0, 1'b0, FB, "uf2");

    // Underflow on the frame-start cycle is counted in the new frame
    sel = 2'd0; vsync = 1'b1;
    px(1'b1, 24'h0, 1'b1, 24'h0, 1'b1, 1'b0, 1'b0, FB, "fsuf");
    chk("fsuf_ucnt", 32'(ucnt), 32'h2);
    chk("fsuf_asel", 32'(asel), 32'h0);
    vsync = 1'b0;
    px(1'b0, 24'h0, 1'b1, 24'h0, 1'b1, 1'b0, 1'b0, 24'h0, "fsuf_idle");
    vsync = 1'b1;
    cyc();
    chk("next_ucnt", 32'(ucnt), 32'h1);
    vsync = 1'b0;

    // Reset in the middle of a src0 burst
    px(1'b1, 24'hE10001, 1'b0, 24'h0, 1'b0, 1'b1, 1'b0, 24'hE10001, "prerst");
    rst = 1'b1; req = 1'b1; d0 = 24'hE20002; e0 = 1'b0;
    #1;
    chk("rst_rd0", 32'(rd0), 32'h0);
    chk("rst_rd1", 32'(rd1), 32'h0);
    cyc();
    chk_reset("midrst");
    rst = 1'b0;
    px(1'b1, 24'hE20002, 1'b0, 24'h0, 1'b0, 1'b0, 1'b0, FB, "postrst");
    req = 1'b0; vsync = 1'b1;
    cyc();
    chk("postrst_fs", 32'(fstart), 32'h1);
    vsync = 1'b0;
    cyc();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
